// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- RV32M multiply/divide unit for the EX stage.
//
// Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. The FSM has three states:
//   IDLE : accept an op when md_start=1 (and no flush)
//   CALC : 32 iterations, one result bit per cycle
//   DONE : md_valid=1, md_result held until md_hold drops
// Divide-by-zero and signed overflow skip CALC and go straight to DONE.
// The iterative datapath shares one accumulator/shift register pair:
//   multiply : shift-add on magnitudes; {acc,q} ends as the 64-bit product
//   divide   : restoring division on magnitudes; q = quotient, acc = remainder
// Signs are fixed up when the result is captured.
//
// Build option: define MULDIV_FAST_MUL_EN to compute funct3 0-3 with a
// single-cycle 33x33 signed multiplier (IDLE->DONE in one stall cycle).
// Division is the same in both builds.
//
// Ports:
//   clk         in   pipeline clock, rising edge
//   cpurst_n    in   asynchronous active-low reset
//   md_start    in   EX-stage instruction is RV32M
//   md_funct3   in   [2:0] operation select
//   md_opa      in   [31:0] rs1 operand
//   md_opb      in   [31:0] rs2 operand
//   md_flush    in   exception/interrupt flush, highest priority
//   md_hold     in   downstream memory stall, keeps DONE
//   mult_stall  out  freeze decode/execute
//   md_result   out  [31:0] rd value
//   md_valid    out  md_result valid (state DONE)
//   md_busy     out  state != IDLE
// ---------------------------------------------------------------------------
module ex_muldiv (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        md_start,
  input  logic [2:0]  md_funct3,
  input  logic [31:0] md_opa,
  input  logic [31:0] md_opb,
  input  logic        md_flush,
  input  logic        md_hold,
  output logic        mult_stall,
  output logic [31:0] md_result,
  output logic        md_valid,
  output logic        md_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_acc;      // mult: product high half; div: partial remainder
  logic [31:0] r_q;        // mult: multiplier / product low half; div: dividend / quotient
  logic [31:0] r_b;        // multiplicand or divisor magnitude
  logic        r_neg_res;  // negate product / quotient
  logic        r_neg_rem;  // negate remainder (dividend sign)
  logic [31:0] r_result;

  // ---- start-cycle operand decode ----------------------------------------
  logic        w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div_zero, w_div_ovf, w_special;
  logic [31:0] w_special_res;
  logic        w_fast;
  logic [31:0] w_fast_res;

  assign w_is_div   = md_funct3[2];
  assign w_a_signed = (md_funct3 == 3'd1) || (md_funct3 == 3'd2) ||
                      (md_funct3 == 3'd4) || (md_funct3 == 3'd6);
  assign w_b_signed = (md_funct3 == 3'd1) || (md_funct3 == 3'd4) ||
                      (md_funct3 == 3'd6);
  assign w_a_neg    = w_a_signed & md_opa[31];
  assign w_b_neg    = w_b_signed & md_opb[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - md_opa) : md_opa;
  assign w_b_mag    = w_b_neg ? (32'd0 - md_opb) : md_opb;

  assign w_div_zero = w_is_div && (md_opb == 32'd0);
  // Only the signed ops (DIV/REM have funct3[0]=0) can overflow.
  assign w_div_ovf  = w_is_div && !md_funct3[0] &&
                      (md_opa == 32'h8000_0000) && (md_opb == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero || w_div_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    if (w_div_zero) w_special_res = md_funct3[1] ? md_opa : 32'hFFFF_FFFF;
    else            w_special_res = md_funct3[1] ? 32'd0  : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  // The 33rd bit carries each operand's sign (zero for unsigned operands),
  // so one signed multiplier covers all four multiply flavours.
  logic signed [32:0] w_fast_a, w_fast_b;
  logic signed [63:0] w_fast_prod;
  assign w_fast_a    = {w_a_signed & md_opa[31], md_opa};
  assign w_fast_b    = {w_b_signed & md_opb[31], md_opb};
  assign w_fast_prod = 64'(w_fast_a) * 64'(w_fast_b);
  assign w_fast      = !w_is_div;
  assign w_fast_res  = (md_funct3[1:0] == 2'd0) ? w_fast_prod[31:0] : w_fast_prod[63:32];
`else
  assign w_fast      = 1'b0;
  assign w_fast_res  = 32'd0;
`endif

  // ---- one iteration of the shared datapath -------------------------------
  logic [32:0] w_mul_sum, w_div_sh, w_div_diff;
  logic [31:0] w_acc_nxt, w_q_nxt;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, otherwise
    // synthesis infers a latch to hold the old value.
    w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);
    w_div_sh   = {r_acc, r_q[31]};
    w_div_diff = w_div_sh - {1'b0, r_b};
    if (r_op[2]) begin
      // Restoring step: keep the subtraction only if it did not borrow.
      w_acc_nxt = w_div_diff[32] ? w_div_sh[31:0] : w_div_diff[31:0];
      w_q_nxt   = {r_q[30:0], ~w_div_diff[32]};
    end else begin
      // Shift-add step: add multiplicand on multiplier LSB, shift {acc,q} right.
      w_acc_nxt = w_mul_sum[32:1];
      w_q_nxt   = {w_mul_sum[0], r_q[31:1]};
    end
  end

  // ---- final result with sign fix-up --------------------------------------
  logic [63:0] w_prod, w_prod_fix;
  logic [31:0] w_calc_res;

  assign w_prod     = {w_acc_nxt, w_q_nxt};
  assign w_prod_fix = r_neg_res ? (64'd0 - w_prod) : w_prod;

  always_comb begin
    case (r_op)
      3'd0:                w_calc_res = w_prod_fix[31:0];
      3'd1, 3'd2, 3'd3:    w_calc_res = w_prod_fix[63:32];
      3'd4, 3'd5:          w_calc_res = r_neg_res ? (32'd0 - w_q_nxt)   : w_q_nxt;
      default:             w_calc_res = r_neg_rem ? (32'd0 - w_acc_nxt) : w_acc_nxt;
    endcase
  end

  // ---- state and datapath registers ---------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_op      <= 3'd0;
      r_acc     <= 32'd0;
      r_q       <= 32'd0;
      r_b       <= 32'd0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= 32'd0;
    end else if (md_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (md_start) begin
            r_op      <= md_funct3;
            r_q       <= w_a_mag;
            r_b       <= w_b_mag;
            r_acc     <= 32'd0;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= 6'd0;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
            end else if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          if (r_cnt == 6'd31) begin
            r_result <= w_calc_res;
            r_cnt    <= 6'd0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DONE: begin
          // md_start is ignored here so a held MD_OP does not restart.
          if (!md_hold) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- outputs ------------------------------------------------------------
  assign mult_stall = cpurst_n && !md_flush &&
                      (((r_state == S_IDLE) && md_start) || (r_state == S_CALC));
  assign md_result  = r_result;
  assign md_valid   = (r_state == S_DONE);
  assign md_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv -- self-checking bench for ex_muldiv.
// Expected results come from a plain-arithmetic RV32M model and are queued
// when an op is issued; a monitor on the falling edge pops and compares each
// time md_valid rises, and re-checks md_result every held DONE cycle.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        cpurst_n = 1'b0;
  logic        md_start = 1'b0;
  logic [2:0]  md_funct3 = 3'd0;
  logic [31:0] md_opa = 32'd0;
  logic [31:0] md_opb = 32'd0;
  logic        md_flush = 1'b0;
  logic        md_hold = 1'b0;
  logic        mult_stall;
  logic [31:0] md_result;
  logic        md_valid;
  logic        md_busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp = 32'd0;
  logic        mon_prev_valid = 1'b0;

  ex_muldiv dut (
    .clk        (clk),
    .cpurst_n   (cpurst_n),
    .md_start   (md_start),
    .md_funct3  (md_funct3),
    .md_opa     (md_opa),
    .md_opb     (md_opb),
    .md_flush   (md_flush),
    .md_hold    (md_hold),
    .mult_stall (mult_stall),
    .md_result  (md_result),
    .md_valid   (md_valid),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference model: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, r;
    logic [63:0] pu, pv;
    sa = $signed(a);
    sb = $signed(b);
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
      3'd1: begin r = sa * sb; pv = r; return pv[63:32]; end
      3'd2: begin r = sa * ub; pv = r; return pv[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        r = sa / sb; pv = r; return pv[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        r = sa % sb; pv = r; return pv[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Stall cycles from the start cycle until DONE.
  function automatic int exp_stalls(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Issue one op from IDLE, count stall cycles, hold DONE for 'hold' cycles.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    int stalls = 0;
    int guard  = 0;
    int vcnt   = 0;
    exp_q.push_back(model(f, a, b));
    md_funct3 = f;
    md_opa    = a;
    md_opb    = b;
    md_start  = 1'b1;
    #1;
    while (!md_valid && guard < 200) begin
      if (mult_stall) stalls++;
      @(posedge clk); #1;
      // Scramble inputs after the start cycle; the latched op must not change.
      md_funct3 = 3'($urandom_range(0, 7));
      md_opa    = $urandom;
      md_opb    = $urandom;
      guard++;
    end
    md_start = 1'b0;
    if (!md_valid) begin
      check("valid_timeout", 32'(md_valid), 32'd1);
      return;
    end
    check("stall_cycles", stalls, exp_stalls(f, a, b));
    while (md_valid && vcnt < 50) begin
      vcnt++;
      md_hold = (vcnt <= hold);
      @(posedge clk); #1;
    end
    md_hold = 1'b0;
    check("valid_cycles", vcnt, hold + 1);
  endtask

  // Monitor: compare on each rising md_valid and on every held DONE cycle.
  always @(negedge clk) begin
    if (!cpurst_n) begin
      mon_prev_valid = 1'b0;
    end else begin
      if (md_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(md_valid), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", md_result, mon_exp);
        end
      end else if (md_valid) begin
        check("result_hold", md_result, mon_exp);
      end
      mon_prev_valid = md_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vc;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    // Reset state, with md_start asserted to show reset wins.
    repeat (2) @(posedge clk); #1;
    md_start  = 1'b1;
    md_funct3 = 3'd4;
    md_opa    = 32'd50;
    md_opb    = 32'd5;
    #1;
    check("rst_stall",  32'(mult_stall), 32'd0);
    check("rst_valid",  32'(md_valid),   32'd0);
    check("rst_busy",   32'(md_busy),    32'd0);
    check("rst_result", md_result,       32'd0);
    md_start = 1'b0;
    cpurst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0);
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1);
    do_op(3'd2, 32'hFFFF_FFFF,  32'd2,         0);
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0);
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0);
    do_op(3'd5, 32'd100,        32'd0,         0);
    do_op(3'd7, 32'd100,        32'd0,         0);
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'd0,          32'd0,         2);
    do_op(3'd7, 32'h1234_5678,  32'h0000_0100, 5);

    // Flush at CALC cycle 10: back to IDLE, no result.
    md_funct3 = 3'd5;
    md_opa    = 32'd12345;
    md_opb    = 32'd3;
    md_start  = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    md_flush = 1'b1;
    #1;
    check("flush_stall", 32'(mult_stall), 32'd0);
    check("flush_busy_before", 32'(md_busy), 32'd1);
    @(posedge clk); #1;
    md_flush = 1'b0;
    check("flush_busy_after",  32'(md_busy),  32'd0);
    check("flush_valid_after", 32'(md_valid), 32'd0);
    vc = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (md_valid) vc++;
    end
    check("flush_no_valid", vc, 0);
    do_op(3'd5, 32'd9, 32'd3, 0);

    // Flush takes priority over a start in IDLE.
    md_funct3 = 3'd4;
    md_opa    = 32'd77;
    md_opb    = 32'd0;
    md_start  = 1'b1;
    md_flush  = 1'b1;
    #1;
    check("flush_start_stall", 32'(mult_stall), 32'd0);
    @(posedge clk); #1;
    check("flush_start_busy", 32'(md_busy), 32'd0);
    md_start = 1'b0;
    md_flush = 1'b0;
    @(posedge clk); #1;

    // Reset pulse mid-CALC: everything clears immediately.
    md_funct3 = 3'd5;
    md_opa    = 32'd1000;
    md_opb    = 32'd7;
    md_start  = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("calc_busy", 32'(md_busy), 32'd1);
    cpurst_n = 1'b0;
    #1;
    check("midrst_stall",  32'(mult_stall), 32'd0);
    check("midrst_valid",  32'(md_valid),   32'd0);
    check("midrst_busy",   32'(md_busy),    32'd0);
    check("midrst_result", md_result,       32'd0);
    @(posedge clk); #1;
    cpurst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd7, 32'd1000, 32'd7, 0);

    // Randomized ops with biased operands and random hold lengths.
    for (int i = 0; i < 32; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(rf, ra, rb, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; rising edge only.
REQ-002 SHALL have ports: cpurst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: md_start  in  1  EX-stage instruction is RV32M (decode-to-execute MD_OP register output).
REQ-004 SHALL have ports: md_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have ports: md_opa  in  32  rs1 operand; md_opb  in  32  rs2 operand.
REQ-006 SHALL have ports: md_flush  in  1  exception/interrupt flush; md_hold  in  1  downstream memory stall.
REQ-007 SHALL have ports: mult_stall  out  1  freeze decode/execute; md_result  out  32  rd value; md_valid  out  1  md_result valid; md_busy  out  1  state != IDLE.

Function
REQ-008 SHALL implement FSM states: IDLE, CALC, DONE.
REQ-009 IDLE with md_start=1 and md_flush=0 SHALL latch operands and funct3, go to CALC (iterative) or DONE (special case or fast multiply).
REQ-010 mult_stall SHALL be combinational: 1 in IDLE when md_start=1 and md_flush=0, 1 in CALC, 0 in DONE, 0 whenever md_flush=1.
REQ-011 CALC SHALL run a 6-bit counter through exactly 32 cycles (one result bit per cycle), then go to DONE.
REQ-012 Iterative op latency SHALL be 33 stall cycles: start cycle plus 32 CALC cycles; md_valid=1 in the 34th cycle.
REQ-013 DONE SHALL drive md_valid=1 and hold md_result stable; it SHALL go to IDLE next cycle when md_hold=0 and stay in DONE while md_hold=1.
REQ-014 DONE SHALL ignore md_start, so a held MD_OP does not restart; back-to-back M ops restart from IDLE.
REQ-015 Multiply SHALL form a 64-bit product: MUL low 32 bits; MULH signed x signed high; MULHSU signed x unsigned high; MULHU unsigned high.
REQ-016 Division SHALL be restoring on magnitudes, with sign fix-up: quotient negative when operand signs differ; remainder takes dividend sign.
REQ-017 Divide by zero SHALL give DIV/DIVU 0xFFFFFFFF and REM/REMU = md_opa, going IDLE->DONE in one stall cycle.
REQ-018 Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF) SHALL give DIV 0x80000000 and REM 0, going IDLE->DONE in one stall cycle.
REQ-019 md_flush=1 in any state SHALL force IDLE next edge with md_valid=0; it takes priority over md_start and md_hold.
REQ-020 Operand or funct3 changes after the start cycle SHALL not affect the result.

Reset
REQ-021 Asserting cpurst_n=0 SHALL immediately force IDLE, counter 0, md_result 0, md_valid 0, md_busy 0, mult_stall 0, including mid-CALC.
REQ-022 After deassertion, the first md_start SHALL be handled as from IDLE; no partial result SHALL survive.

Configuration
REQ-023 Macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
REQ-024 With MULDIV_FAST_MUL_EN defined, funct3 0-3 SHALL compute with a single-cycle 33x33 signed multiplier, going IDLE->DONE with 1 stall cycle.
REQ-025 Without MULDIV_FAST_MUL_EN, multiply SHALL use 32-cycle shift-add through CALC with REQ-012 latency; division is identical in both builds.

Verification
REQ-026 MUL 7 x 0xFFFFFFFD -> md_result 0xFFFFFFEB; stall 1 cycle with macro, 33 without.
REQ-027 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-028 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100 after 1 stall cycle.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, one stall cycle.
REQ-030 md_flush at CALC cycle 10 -> IDLE next edge, mult_stall 0, md_valid never asserted; a subsequent DIVU 9/3 -> 3.
REQ-031 md_hold=1 for 5 cycles in DONE -> md_valid and md_result stable for 6 cycles; cpurst_n pulse mid-CALC -> all outputs 0 immediately.
